// File: rtl/mem_store_responder_if.sv
// Bundle of the CPU store port, status read path, drain stream and sticky
// flags seen by the store responder.
interface mem_store_responder_if;
    logic        MemWrite;
    logic [31:0] ALUResult;
    logic [31:0] WriteData;
    logic [31:0] ReadData;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_addr;
    logic [31:0] out_data;
    logic        done;
    logic [31:0] done_data;
    logic        overflow;
    logic        misalign;

    modport slave (
        input  MemWrite, ALUResult, WriteData, out_ready,
        output ReadData, out_valid, out_addr, out_data,
        output done, done_data, overflow, misalign
    );

    modport master (
        output MemWrite, ALUResult, WriteData, out_ready,
        input  ReadData, out_valid, out_addr, out_data,
        input  done, done_data, overflow, misalign
    );
endinterface

// File: rtl/mem_store_responder.sv
// Captures aligned CPU stores into a FIFO drained over valid/ready, tracks
// done/overflow/misalign sticky flags and exposes them as a status word.
module mem_store_responder #(
    parameter int          DEPTH       = 8,
    parameter logic [31:0] DONE_ADDR   = 32'h0000_0064,
    parameter logic [31:0] STATUS_ADDR = 32'h0000_0F00,
    parameter logic [31:0] CLEAR_ADDR  = 32'h0000_0F04
) (
    input  logic                  clk,
    input  logic                  reset,
    mem_store_responder_if.slave  bus
);
    localparam int          AW      = $clog2(DEPTH);
    localparam logic [AW:0] LP_FULL = (AW+1)'(DEPTH);

    logic [63:0]   r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          r_done;
    logic [31:0]   r_done_data;
    logic          r_overflow;
    logic          r_misalign;

    logic w_misaligned;
    logic w_clear;
    logic w_push_req;
    logic w_valid;
    logic w_pop;
    logic w_push;
    logic w_drop;
    logic w_done_hit;

    assign w_misaligned = bus.MemWrite && (bus.ALUResult[1:0] != 2'b00);
    assign w_clear      = bus.MemWrite && !w_misaligned && (bus.ALUResult == CLEAR_ADDR);
    assign w_push_req   = bus.MemWrite && !w_misaligned && !w_clear;
    assign w_valid      = (r_count != '0);
    assign w_pop        = w_valid && bus.out_ready;
    // A full FIFO still accepts a store when the head leaves in the same cycle.
    assign w_push       = w_push_req && ((r_count != LP_FULL) || w_pop);
    assign w_drop       = w_push_req && !w_push;
    assign w_done_hit   = w_push_req && (bus.ALUResult == DONE_ADDR);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {bus.ALUResult, bus.WriteData};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_done      <= 1'b0;
            r_done_data <= '0;
            r_overflow  <= 1'b0;
            r_misalign  <= 1'b0;
        end else begin
            if (w_done_hit) begin
                r_done_data <= bus.WriteData;
            end
            if (w_clear) begin
                r_done     <= 1'b0;
                r_overflow <= 1'b0;
                r_misalign <= 1'b0;
            end else begin
                if (w_done_hit)   r_done     <= 1'b1;
                if (w_drop)       r_overflow <= 1'b1;
                if (w_misaligned) r_misalign <= 1'b1;
            end
        end
    end

    logic [63:0] w_head;
    assign w_head = w_valid ? r_mem[r_rd_ptr] : 64'h0;

    assign bus.out_valid = w_valid;
    assign bus.out_addr  = w_head[63:32];
    assign bus.out_data  = w_head[31:0];
    assign bus.done      = r_done;
    assign bus.done_data = r_done_data;
    assign bus.overflow  = r_overflow;
    assign bus.misalign  = r_misalign;

    assign bus.ReadData = (bus.ALUResult == STATUS_ADDR)
                        ? {16'h0, 8'(r_count), 4'h0, r_misalign, r_overflow, r_done, w_valid}
                        : 32'h0;
endmodule

// File: doc/mem_store_responder.md
# mem_store_responder

Data-memory-side responder for the single-cycle core's store port. It captures every aligned CPU store (`MemWrite`, `ALUResult` as address, `WriteData`) into a FIFO and drains the FIFO to a downstream consumer over a valid/ready stream. It also flags program completion when a store hits a configured done address, and exposes a readable status word. It sits beside `TOP` and replaces the bench's ad-hoc store checking with a synthesizable observer and peripheral.

## Interface
Parameters:
- `DEPTH`, 8 — FIFO entries; power of two, ≥2.
- `DONE_ADDR`, 32'h0000_0064 — a store here sets `done`.
- `STATUS_ADDR`, 32'h0000_0F00 — read address of the status word.
- `CLEAR_ADDR`, 32'h0000_0F04 — a store here clears the sticky flags.

Ports:
- `clk` in 1 — single clock; all state updates on the rising edge.
- `reset` in 1 — asynchronous, active-low.
- `MemWrite` in 1 — CPU store strobe.
- `ALUResult` in 32 — CPU store/read address.
- `WriteData` in 32 — CPU store data.
- `ReadData` out 32 — combinational status read.
- `out_valid` out 1 — FIFO head valid.
- `out_ready` in 1 — consumer accepts head.
- `out_addr` out 32 — head entry address.
- `out_data` out 32 — head entry data.
- `done` out 1 — sticky; a store to `DONE_ADDR` has occurred.
- `done_data` out 32 — data of the most recent `DONE_ADDR` store.
- `overflow` out 1 — sticky; a store was dropped because the FIFO was full.
- `misalign` out 1 — sticky; a store with `ALUResult[1:0]≠0` was seen.

## Operation
- Store classification at the rising edge when `MemWrite`=1:
  - `ALUResult[1:0]≠0`: set `misalign`, no push.
  - `ALUResult==CLEAR_ADDR`: clear `done`, `overflow` and `misalign`, no push. A clear takes priority over any set in the same cycle.
  - Otherwise: push {`ALUResult`, `WriteData`}. If `ALUResult==DONE_ADDR`, also set `done` and load `done_data`.
- FIFO: circular buffer with read/write pointers of log2(`DEPTH`) bits, wrapping modulo `DEPTH`. `count` is log2(`DEPTH`)+1 bits, range 0..`DEPTH`.
  - Push is accepted if `count<DEPTH`, or if `count==DEPTH` and a pop happens in the same cycle.
  - Otherwise the push is dropped and `overflow` is set.
  - A `DONE_ADDR` store that is dropped still sets `done` and loads `done_data`.
- Pop occurs when `out_valid && out_ready`; the read pointer advances.
  - Simultaneous push and pop: `count` is unchanged and both pointers advance.
  - Pop is impossible when empty because `out_valid`=0.
- `out_valid` = (`count≠0`). `out_addr`/`out_data` are driven from the head entry. Head data is stable while `out_valid && !out_ready`.
- `ReadData`:
  - If `ALUResult==STATUS_ADDR`: {`count` zero-extended into [31:8], `misalign` in [3], `overflow` in [2], `done` in [1], `out_valid` in [0]}, with `count` placed at bits [15:8].
  - Else: 32'h0.
  - `ReadData` is purely combinational and independent of `MemWrite`.
- Reset (asynchronous, `reset`=0): pointers, `count`, `done`, `overflow` and `misalign` go to 0; `done_data` goes to 0. Therefore `out_valid`=0, `out_addr`=0 and `out_data`=0 (head outputs are forced to 0 when empty). FIFO storage contents are don't-care.
- Reset asserted mid-stream: all queued entries are discarded immediately. No pop or push occurs in the cycle `reset` releases unless inputs request it on the following rising edge.

## Timing
- Store-to-visible latency is 1 cycle: a store sampled at edge N gives `out_valid`=1 and `done`=1 after edge N.
- Pop latency is 1 cycle: the head advances after the edge where `out_valid && out_ready`.
- The maximum sustained throughput is one push and one pop per cycle.
- The `ReadData` path is combinational from `ALUResult` to `ReadData` within the same cycle.
- Sticky flags change only on rising edges or asynchronous reset.
- The CPU is never stalled: full-FIFO stores are dropped, never back-pressured.

## Test plan
- Reset, then store 45600 to 0x64 with `out_ready`=0 → next cycle `done`=1, `done_data`=45600, `out_valid`=1, `out_addr`=0x64, `out_data`=45600.
- Fill the FIFO with 8 stores of data 1..8 (`out_ready`=0), then store 9 → `overflow`=1. Drain with `out_ready`=1 → data 1..8 in order, then `out_valid`=0.
- Hold `count`=8 and issue a store of 0xAA with `out_ready`=1 in the same cycle → `overflow` stays 0, `count` stays 8, and 0xAA is the last entry drained.
- Store to 0x66 → `misalign`=1, no push. Drive `ALUResult`=0xF00 → `ReadData`=32'h0000_0008 (`misalign` bit set). Store to 0xF04 → all sticky flags go to 0.
- Push 3 entries, assert `reset`=0 between clock edges → `out_valid`, `count`, `done` and `overflow` go to 0 immediately, without waiting for a clock edge.
- Run 20 push/pop pairs at random `out_ready` → output order matches input order across pointer wrap, and `count` never exceeds 8.
